// File: rtl/prime_buffer.sv
`default_nettype none
// ============================================================================
// Module      : prime_buffer
// Description : Prefetch FIFO in front of primegen. Requests a new prime
//               whenever a slot is free, stores results in a circular buffer
//               exposed as a valid/ready stream, and raises a sticky error on
//               generator faults or non-increasing results.
// Revision    : 1.0 - initial release
// ============================================================================
module prime_buffer #(
  parameter int WIDTH_LOG = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic                      gen_go,
  input  logic                      gen_ready,
  input  logic                      gen_error,
  input  logic [(1<<WIDTH_LOG)-1:0] gen_res,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(1<<WIDTH_LOG)-1:0] out_data,
  output logic                      out_error,
  output logic [DEPTH_LOG:0]        count
);

  localparam int WIDTH = 1 << WIDTH_LOG;
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] C_DEPTH = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG-1:0] C_PTR_ONE = DEPTH_LOG'(1);

  typedef enum logic [1:0] {
    ISSUE     = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    HALT      = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_gen_go;
  logic                   w_go_nxt;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_err_set;
  logic [DEPTH_LOG:0]     w_count_after_pop;
  logic [WIDTH-1:0]       r_last;
  logic                   r_have_last;
  logic                   r_error;
  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [DEPTH_LOG-1:0]   r_wr_ptr;
  logic [DEPTH_LOG-1:0]   r_rd_ptr;
  logic [DEPTH_LOG:0]     r_count;

  // Pop handshake; the free-slot test uses occupancy after this cycle's pop.
  assign w_pop             = (r_count != '0) && out_ready;
  assign w_count_after_pop = r_count - (DEPTH_LOG+1)'(w_pop);

  // Request FSM: next state, go request, push and fault detection.
  always_comb begin
    w_state_nxt = r_state;
    w_go_nxt    = 1'b0;
    w_push      = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ISSUE: begin
        if (gen_ready && (w_count_after_pop < C_DEPTH)) begin
          w_go_nxt    = 1'b1;
          w_state_nxt = WAIT_BUSY;
        end
      end
      // The generator keeps ready high for a couple of edges after go;
      // waiting for it to fall keeps a stale ready from looking like a result.
      WAIT_BUSY: begin
        if (!gen_ready) begin
          w_state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (gen_ready) begin
          if (gen_error) begin
            w_err_set   = 1'b1;
            w_state_nxt = HALT;
          end else if (r_have_last && (gen_res <= r_last)) begin
            // Non-increasing result means the generator wrapped its width.
            w_err_set   = 1'b1;
            w_state_nxt = HALT;
          end else begin
            w_push      = 1'b1;
            w_state_nxt = ISSUE;
          end
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = ISSUE;
      end
    endcase
  end

  // FSM state, registered go pulse, last-pushed value and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ISSUE;
      r_gen_go    <= 1'b0;
      r_last      <= '0;
      r_have_last <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_gen_go <= w_go_nxt;
      if (w_push) begin
        r_last      <= gen_res;
        r_have_last <= 1'b1;
      end
      if (w_err_set) begin
        r_error <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (DEPTH_LOG+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (DEPTH_LOG+1)'(1);
      end
    end
  end

  // Storage array; contents are masked on the output while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= gen_res;
    end
  end

  assign gen_go    = r_gen_go;
  assign out_valid = (r_count != '0);
  assign out_data  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign out_error = r_error;
  assign count     = r_count;

endmodule
`default_nettype wire
